commit_rob: RTL and testbench
=============================

# commit_rob

Reorder buffer for the I2OI core. It allocates entries in program order at dispatch, accepts out-of-order results from the execute stage by tag, and retires completed entries strictly in order to the commit stage. Commit feeds the ARF write port or the finished store buffer. The block sits downstream of execute and upstream of ARF write-back; it is the only path by which results become architectural.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- TAG_W, 3, tag width; equals log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous discard of every entry.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  high when an entry is free.
- disp_rd  in  5  destination register.
- disp_regwrite  in  1  instruction writes a register.
- disp_store  in  1  instruction is a store.
- disp_tag  out  TAG_W  tag assigned to the current dispatch; equals the tail pointer.
- cmp_valid  in  1  execute result valid.
- cmp_tag  in  TAG_W  entry being completed.
- cmp_data  in  32  result (ALU result, load data, or store address).
- commit_valid  out  1  head entry is completed and presentable.
- commit_ready  in  1  consumer accepts the commit.
- commit_rd  out  5  head destination register.
- commit_data  out  32  head result.
- commit_regwrite  out  1  head writes the ARF.
- commit_store  out  1  head is a store; the store buffer releases it.
- count  out  TAG_W+1  occupied entries, 0..DEPTH.

## Operation
- State:
  - head and tail pointers, each TAG_W bits, wrapping modulo DEPTH.
  - count, TAG_W+1 bits.
  - Per-entry fields: busy, done, rd, regwrite, store, data.
- Dispatch fires when disp_valid && disp_ready:
  - Writes the entry at tail with busy=1 and done=0, plus the rd, regwrite and store fields.
  - tail increments, wrapping from DEPTH-1 to 0.
- Completion fires when cmp_valid:
  - If entry[cmp_tag].busy, sets done=1 and writes data.
  - If the entry is not busy, the completion is ignored with no state change.
  - A completion whose tag matches the entry being dispatched in the same cycle is ignored; the dispatch write wins.
- Commit fires when commit_valid && commit_ready:
  - Clears busy and done at head.
  - head increments, with wrap.
- Count update:
  - Increments on dispatch only.
  - Decrements on commit only.
  - Unchanged when both fire in the same cycle.
- Flush:
  - head=tail=count=0; every busy and done bit is cleared.
  - Has priority over dispatch, completion and commit in the same cycle; none of those take effect.
- The stored data payload is not cleared on commit or flush; only the busy and done flags are.

## Timing
- Reset values (asynchronous assertion; all registers, payload included, cleared to 0):
  - head=tail=count=0.
  - disp_ready=1, disp_tag=0.
  - commit_valid=0, commit_rd=0, commit_data=0, commit_regwrite=0, commit_store=0.
- Combinational outputs from registered state:
  - disp_ready = (count != DEPTH), with no same-cycle bypass. When full, a commit in cycle N frees a slot that becomes visible in cycle N+1.
  - disp_tag = tail.
  - commit_valid = busy[head] && done[head].
  - commit_rd, commit_data, commit_regwrite and commit_store are taken from entry[head].
- Latency:
  - A completion in cycle N makes commit_valid visible in cycle N+1 at the earliest.
  - Dispatch to earliest commit is 2 cycles: dispatch in N, complete in N+1, commit in N+2.
- Commit holds while commit_valid && !commit_ready; all commit outputs stay stable.
- Throughput is one dispatch, one completion and one commit per cycle, all concurrently.
- Empty (count=0): commit_valid=0; a stray completion is ignored.
- Full (count=DEPTH): head==tail, and disp_ready=0 regardless of disp_valid.
- Reset mid-operation discards all entries immediately; no commit occurs on the reset edge.

## Test plan
- Reset, then dispatch rd=5 with regwrite, then complete tag 0 with data 0x0000000A and hold commit_ready=1. Required: disp_tag=0; commit_valid rises one cycle after completion with commit_rd=5, commit_data=0x0A, commit_regwrite=1; count returns to 0.
- Out of order: dispatch tags 0, 1, 2; complete them in order 2, 1, 0 with data 0x22, 0x11, 0x00. Required: commits occur in order 0, 1, 2 on consecutive cycles with matching data; commit_valid stays low until tag 0 is done.
- Full and wrap, DEPTH=8: dispatch 8 entries. Required: disp_ready=0 and count=8. Then complete and commit 1 entry and dispatch again. Required: disp_ready returns high the cycle after the commit, and the new disp_tag=0 (wrapped).
- Backpressure: head done, commit_ready=0 for 3 cycles. Required: commit_valid=1 and outputs stable for all 3 cycles; exactly one commit when commit_ready rises.
- Flush: with 5 entries busy, drive flush together with disp_valid and cmp_valid. Required: count=0 and disp_tag=0 next cycle; the simultaneous dispatch and completion are discarded.
- Async reset pulsed mid-run with 3 entries pending. Required: all outputs return to reset values without a clock edge; a completion to a stale tag afterwards is ignored.

Source files
------------

// File: rtl/commit_rob_if.sv
// rtl/commit_rob_if.sv - dispatch, completion and commit channels of the reorder buffer
//
// Purpose: bundles the handshakes around commit_rob.
//   slave  : the reorder buffer side
//   master : the pipeline side (dispatch, execute and commit stage)
// Signals:
//   flush                            discard every entry (synchronous)
//   disp_valid/disp_ready            dispatch handshake
//   disp_rd/disp_regwrite/disp_store dispatched instruction fields
//   disp_tag                         tag given to the current dispatch
//   cmp_valid/cmp_tag/cmp_data       execute result by tag
//   commit_valid/commit_ready        in-order retire handshake
//   commit_rd/commit_data            head entry payload
//   commit_regwrite/commit_store     head entry kind
//   count                            occupied entries
interface commit_rob_if #(
  parameter int TAG_W = 3
);
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [4:0]       disp_rd;
  logic             disp_regwrite;
  logic             disp_store;
  logic [TAG_W-1:0] disp_tag;
  logic             cmp_valid;
  logic [TAG_W-1:0] cmp_tag;
  logic [31:0]      cmp_data;
  logic             commit_valid;
  logic             commit_ready;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_data;
  logic             commit_regwrite;
  logic             commit_store;
  logic [TAG_W:0]   count;

  modport slave (
    input  flush, disp_valid, disp_rd, disp_regwrite, disp_store,
    input  cmp_valid, cmp_tag, cmp_data, commit_ready,
    output disp_ready, disp_tag, commit_valid, commit_rd, commit_data,
    output commit_regwrite, commit_store, count
  );

  modport master (
    output flush, disp_valid, disp_rd, disp_regwrite, disp_store,
    output cmp_valid, cmp_tag, cmp_data, commit_ready,
    input  disp_ready, disp_tag, commit_valid, commit_rd, commit_data,
    input  commit_regwrite, commit_store, count
  );
endinterface

// File: rtl/commit_rob.sv
// rtl/commit_rob.sv - in-order retire reorder buffer with tag-addressed completion
//
// Purpose: allocates entries in program order, accepts out-of-order results
// by tag and presents completed entries strictly in order to commit.
// Ports:
//   clk  clock, all state updates on the rising edge
//   rst  asynchronous active-low reset, clears every register incl. payload
//   bus  commit_rob_if.slave (dispatch, completion, commit, flush, count)
module commit_rob #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input logic         clk,
  input logic         rst,
  commit_rob_if.slave bus
);

  localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] PTR_ONE    = TAG_W'(1);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count_q;

  logic        busy     [DEPTH];
  logic        done     [DEPTH];
  logic [4:0]  rd       [DEPTH];
  logic        regwrite [DEPTH];
  logic        store    [DEPTH];
  logic [31:0] data     [DEPTH];

  logic disp_fire;
  logic cmp_fire;
  logic commit_fire;
  logic commit_valid_int;
  logic disp_ready_int;

  // Ready depends only on registered occupancy: a slot freed by a commit
  // becomes usable the following cycle.
  assign disp_ready_int   = (count_q != FULL_COUNT);
  assign commit_valid_int = busy[head] && done[head];

  assign disp_fire   = bus.disp_valid && disp_ready_int;
  assign commit_fire = commit_valid_int && bus.commit_ready;
  // A result aimed at the slot being (re)allocated this cycle is stale;
  // the fresh allocation wins.
  assign cmp_fire    = bus.cmp_valid && busy[bus.cmp_tag] &&
                       !(disp_fire && (bus.cmp_tag == tail));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i]     <= 1'b0;
        done[i]     <= 1'b0;
        rd[i]       <= '0;
        regwrite[i] <= 1'b0;
        store[i]    <= 1'b0;
        data[i]     <= '0;
      end
    end else if (bus.flush) begin
      // Payload is left in place; only the flags decide liveness.
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
      end
    end else begin
      if (disp_fire) begin
        busy[tail]     <= 1'b1;
        done[tail]     <= 1'b0;
        rd[tail]       <= bus.disp_rd;
        regwrite[tail] <= bus.disp_regwrite;
        store[tail]    <= bus.disp_store;
        tail           <= tail + PTR_ONE;
      end
      if (cmp_fire) begin
        done[bus.cmp_tag] <= 1'b1;
        data[bus.cmp_tag] <= bus.cmp_data;
      end
      // Head and tail never coincide while both fire (that needs full and
      // empty at once), so the commit clear cannot collide with dispatch.
      if (commit_fire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + PTR_ONE;
      end
      if (disp_fire && !commit_fire) begin
        count_q <= count_q + CNT_ONE;
      end else if (commit_fire && !disp_fire) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    bus.disp_ready      = disp_ready_int;
    bus.disp_tag        = tail;
    bus.commit_valid    = commit_valid_int;
    bus.commit_rd       = rd[head];
    bus.commit_data     = data[head];
    bus.commit_regwrite = regwrite[head];
    bus.commit_store    = store[head];
    bus.count           = count_q;
  end

endmodule

// File: tb/tb_commit_rob.sv
// tb/tb_commit_rob.sv - self-checking bench for commit_rob
module tb_commit_rob;

  localparam int DEPTH = 8;
  localparam int TAG_W = 3;

  logic clk;
  logic rst;

  commit_rob_if #(.TAG_W(TAG_W)) bus();

  commit_rob #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        dv;
    logic [4:0]  rd;
    logic        rw;
    logic        st;
    logic        cv;
    logic [2:0]  ctag;
    logic [31:0] cdata;
    logic        cr;
    logic [2:0]  e_tag;
    logic [3:0]  e_count;
    logic        e_cv;
    logic [31:0] e_cdata;
  } vec_t;

  typedef struct {
    logic [2:0] tag;
    logic [4:0] rd;
    logic       rw;
    logic       st;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic        mbusy [DEPTH];
  logic [31:0] mdata [DEPTH];
  logic [2:0]  mtail;
  int          mcount;

  function automatic vec_t mk(logic dv, logic [4:0] rd, logic rw, logic st,
                              logic cv, logic [2:0] ctag, logic [31:0] cdata,
                              logic cr, logic [2:0] e_tag, logic [3:0] e_count,
                              logic e_cv, logic [31:0] e_cdata);
    vec_t v;
    v.dv = dv; v.rd = rd; v.rw = rw; v.st = st;
    v.cv = cv; v.ctag = ctag; v.cdata = cdata; v.cr = cr;
    v.e_tag = e_tag; v.e_count = e_count; v.e_cv = e_cv; v.e_cdata = e_cdata;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic dv, logic [4:0] rd, logic rw, logic st, logic cv,
                       logic [2:0] ctag, logic [31:0] cdata, logic cr, logic fl);
    bus.disp_valid    = dv;
    bus.disp_rd       = rd;
    bus.disp_regwrite = rw;
    bus.disp_store    = st;
    bus.cmp_valid     = cv;
    bus.cmp_tag       = ctag;
    bus.cmp_data      = cdata;
    bus.commit_ready  = cr;
    bus.flush         = fl;
  endtask

  task automatic model_clear();
    sb.delete();
    for (int i = 0; i < DEPTH; i++) mbusy[i] = 1'b0;
    mtail  = '0;
    mcount = 0;
  endtask

  // Scores any commit seen this cycle, advances the model, then clocks.
  task automatic tick();
    sb_t  s;
    logic cfire;
    logic dfire;
    logic popped;
    popped = 1'b0;
    cfire  = bus.commit_valid && bus.commit_ready && !bus.flush;
    if (cfire) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra_commit actual=1 required=0");
      end else begin
        s = sb.pop_front();
        popped = 1'b1;
        chk("sb_commit_rd", bus.commit_rd, s.rd);
        chk("sb_commit_regwrite", bus.commit_regwrite, s.rw);
        chk("sb_commit_store", bus.commit_store, s.st);
        chk("sb_commit_data", bus.commit_data, mdata[s.tag]);
      end
    end
    if (bus.flush) begin
      model_clear();
    end else begin
      dfire = bus.disp_valid && (mcount != DEPTH);
      if (bus.cmp_valid && mbusy[bus.cmp_tag] && !(dfire && bus.cmp_tag == mtail))
        mdata[bus.cmp_tag] = bus.cmp_data;
      if (popped) begin
        mbusy[s.tag] = 1'b0;
        mcount--;
      end
      if (dfire) begin
        s.tag = mtail;
        s.rd  = bus.disp_rd;
        s.rw  = bus.disp_regwrite;
        s.st  = bus.disp_store;
        sb.push_back(s);
        mbusy[mtail] = 1'b1;
        mtail = mtail + 3'd1;
        mcount++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdata[i] = '0;
    model_clear();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset_count", bus.count, 0);
    chk("reset_disp_ready", bus.disp_ready, 1);
    chk("reset_disp_tag", bus.disp_tag, 0);
    chk("reset_commit_valid", bus.commit_valid, 0);
    chk("reset_commit_data", bus.commit_data, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    //            dv rd  rw st cv tag data          cr  etag ecnt ecv ecdata
    vecs.push_back(mk(1, 5, 1, 0, 0, 0, 32'h0,      0,  0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 32'hA,      1,  1, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  1, 1, 1, 32'hA));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 32'h0,      1,  1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 2, 1, 0, 0, 0, 32'h0,      1,  2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 3, 1, 0, 0, 0, 32'h0,      1,  3, 2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 32'h22,     1,  4, 3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'h11,     1,  4, 3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 32'h00,     1,  4, 3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  4, 3, 1, 32'h00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  4, 2, 1, 32'h11));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  4, 1, 1, 32'h22));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  4, 0, 0, 32'h0));
    vecs.push_back(mk(1, 7, 0, 1, 0, 0, 32'h0,      0,  4, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 32'h1234,   0,  5, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      0,  5, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      0,  5, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      0,  5, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  5, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 32'hDEAD,   1,  5, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  5, 0, 0, 32'h0));
    vecs.push_back(mk(1, 9, 1, 0, 1, 5, 32'hBAD,    1,  5, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  6, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 32'h55,     1,  6, 1, 0, 32'h0));
    vecs.push_back(mk(1, 10, 1, 0, 0, 0, 32'h0,     1,  6, 1, 1, 32'h55));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,      1,  7, 1, 0, 32'h0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.dv, v.rd, v.rw, v.st, v.cv, v.ctag, v.cdata, v.cr, 0);
      chk($sformatf("v%0d_disp_tag", i), bus.disp_tag, v.e_tag);
      chk($sformatf("v%0d_count", i), bus.count, v.e_count);
      chk($sformatf("v%0d_disp_ready", i), bus.disp_ready, v.e_count != 4'd8);
      chk($sformatf("v%0d_commit_valid", i), bus.commit_valid, v.e_cv);
      if (v.e_cv) chk($sformatf("v%0d_commit_data", i), bus.commit_data, v.e_cdata);
      tick();
    end

    // Flush with five entries live, racing a dispatch and a completion.
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(12 + i), 1, 0, 0, 0, 0, 1, 0);
      tick();
    end
    chk("pre_flush_count", bus.count, 5);
    drive(1, 20, 1, 0, 1, 6, 32'h66, 1, 1);
    tick();
    chk("flush_count", bus.count, 0);
    chk("flush_disp_tag", bus.disp_tag, 0);
    chk("flush_commit_valid", bus.commit_valid, 0);
    drive(0, 0, 0, 0, 1, 6, 32'h99, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("post_flush_cmp_ignored", bus.commit_valid, 0);
    chk("post_flush_count", bus.count, 0);

    // Fill to DEPTH, retire one, and dispatch into the wrapped slot.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'(16 + i), 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    chk("full_disp_ready", bus.disp_ready, 0);
    chk("full_count", bus.count, 8);
    chk("full_disp_tag", bus.disp_tag, 0);
    drive(1, 30, 1, 0, 1, 0, 32'h77, 0, 0);
    tick();
    chk("full_hold_ready", bus.disp_ready, 0);
    chk("full_commit_valid", bus.commit_valid, 1);
    drive(1, 30, 1, 0, 0, 0, 0, 1, 0);
    chk("full_commit_cycle_ready", bus.disp_ready, 0);
    tick();
    chk("after_commit_ready", bus.disp_ready, 1);
    chk("after_commit_count", bus.count, 7);
    chk("wrap_disp_tag", bus.disp_tag, 0);
    drive(1, 24, 1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("refill_count", bus.count, 8);
    chk("refill_disp_tag", bus.disp_tag, 1);

    // Asynchronous reset with three entries pending, head already done.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(11 + i), 1, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0, 32'hAB, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_commit_valid", bus.commit_valid, 1);
    chk("pre_reset_commit_data", bus.commit_data, 32'hAB);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_disp_ready", bus.disp_ready, 1);
    chk("arst_disp_tag", bus.disp_tag, 0);
    chk("arst_commit_valid", bus.commit_valid, 0);
    chk("arst_commit_rd", bus.commit_rd, 0);
    chk("arst_commit_data", bus.commit_data, 0);
    chk("arst_commit_regwrite", bus.commit_regwrite, 0);
    model_clear();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 1, 1, 32'h5A5A, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("stale_cmp_commit_valid", bus.commit_valid, 0);
    chk("stale_cmp_count", bus.count, 0);
    tick();
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
